// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider among NREQ requesters.
// Optional: `define DIV_ZERO_BYPASS_EN to answer y==0 requests without using the divider.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 63
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q_out,
  output logic [W-1:0]      r_out,
  output logic              err_out,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              div_go,
  output logic [W-1:0]      div_x,
  output logic [W-1:0]      div_y,
  input  logic              div_done,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r,
  input  logic              div_error
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d, win;
  logic           found;
  logic [W-1:0]   x_q, x_d, y_q, y_d, q_q, q_d, r_q, r_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Scan from the slot after the last winner so it lands at lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    x_d     = x_q;
    y_d     = y_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ack     = '0;
    div_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = win;
          x_d     = x_in[int'(win)*W +: W];
          y_d     = y_in[int'(win)*W +: W];
          state_d = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (y_in[int'(win)*W +: W] == '0) begin
            q_d     = '0;
            r_d     = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        div_go  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // First WAIT cycle may still see the previous op's done level.
        if (div_done && cnt_q != '0) begin
          q_d     = div_q;
          r_d     = div_r;
          err_d   = div_error;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          q_d     = '0;
          r_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ack[gid_q] = 1'b1;
        ptr_d      = gid_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gid_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;
  assign div_x    = x_q;
  assign div_y    = y_q;
  assign q_out    = q_q;
  assign r_out    = r_q;
  assign err_out  = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider that keeps a stale done
// for one cycle after go and can be told to never finish.
module tb_div_arbiter;
  localparam int NREQ = 4, IDW = 2, W = 4, TIMEOUT = 63;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in, y_in;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q_out, r_out;
  logic              err_out, busy;
  logic [IDW-1:0]    grant_id;
  logic              div_go;
  logic [W-1:0]      div_x, div_y;
  logic              div_done;
  logic [W-1:0]      div_q, div_r;
  logic              div_error;

  div_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .q_out(q_out), .r_out(r_out), .err_out(err_out),
    .busy(busy), .grant_id(grant_id), .div_go(div_go),
    .div_x(div_x), .div_y(div_y), .div_done(div_done),
    .div_q(div_q), .div_r(div_r), .div_error(div_error)
  );

  always #5 CLK = ~CLK;

  // Divider model: done drops one cycle after go, rises 4 cycles after go.
  logic         hang;
  int           m_lat;
  logic [W-1:0] p_q, p_r;
  logic         p_err;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_done <= 1'b0; div_q <= '0; div_r <= '0; div_error <= 1'b0;
      m_lat <= 0; p_q <= '0; p_r <= '0; p_err <= 1'b0;
    end else if (div_go) begin
      m_lat <= 4;
      if (div_y == '0) begin
        p_q <= '1; p_r <= div_x; p_err <= 1'b1;
      end else begin
        p_q <= div_x / div_y; p_r <= div_x % div_y; p_err <= 1'b0;
      end
    end else if (m_lat != 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 4) div_done <= 1'b0;
      if (m_lat == 1 && !hang) begin
        div_done <= 1'b1; div_q <= p_q; div_r <= p_r; div_error <= p_err;
      end
    end
  end

  int gocnt = 0;
  always @(negedge CLK) if (div_go) gocnt++;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ack == '0 && n < 300);
    chk("ack_seen", 32'(ack != '0), 1);
  endtask

  task automatic setop(input int i, input int x, input int y);
    x_in[i*W +: W] = W'(x);
    y_in[i*W +: W] = W'(y);
  endtask

  int n, g0;
  int eq[4] = '{3, 1, 1, 2};
  int er[4] = '{3, 4, 0, 2};

  initial begin
    RST = 1'b1; req = '0; x_in = '0; y_in = '0; hang = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_go", div_go, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_divx", div_x, 0);
    RST = 1'b0;
    @(negedge CLK);

    // single op 13/4
    setop(0, 13, 4); req = 4'b0001; g0 = gocnt;
    @(negedge CLK);
    chk("single_go", div_go, 1);
    chk("single_divx", div_x, 13);
    chk("single_divy", div_y, 4);
    chk("single_busy", busy, 1);
    wait_ack(n);
    chk("single_lat", n, 6);
    chk("single_ack", ack, 4'b0001);
    chk("single_q", q_out, 3);
    chk("single_r", r_out, 1);
    chk("single_err", err_out, 0);
    chk("single_gocnt", gocnt - g0, 1);
    req = '0;
    @(negedge CLK);
    chk("single_idle", busy, 0);

    // all four at once after reset
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    setop(0, 15, 4); setop(1, 9, 5); setop(2, 7, 7); setop(3, 14, 6);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      chk("rr_ack", ack, 32'(1 << k));
      chk("rr_q", q_out, eq[k]);
      chk("rr_r", r_out, er[k]);
      req[k] = 1'b0;
    end
    @(negedge CLK);
    chk("rr_idle", busy, 0);

    // fairness between 0 and 2 held high
    setop(0, 8, 2); setop(2, 11, 5);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      chk("fair_gid", grant_id, (k % 2) * 2);
      chk("fair_ack", ack, (k % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("fair_q", q_out, (k % 2 == 0) ? 4 : 2);
      chk("fair_r", r_out, (k % 2 == 0) ? 0 : 1);
    end
    req = '0;
    @(negedge CLK);

    // divide by zero
    setop(1, 9, 0); req = 4'b0010; g0 = gocnt;
    wait_ack(n);
    chk("dz_ack", ack, 4'b0010);
    chk("dz_err", err_out, 1);
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_lat", n, 1);
    chk("dz_gocnt", gocnt - g0, 0);
    chk("dz_q", q_out, 0);
    chk("dz_r", r_out, 0);
`else
    chk("dz_lat", n, 7);
    chk("dz_gocnt", gocnt - g0, 1);
`endif
    req = '0;
    @(negedge CLK);

    // timeout, then a normal op
    hang = 1'b1; setop(0, 5, 1); req = 4'b0001;
    wait_ack(n);
    chk("to_lat", n, TIMEOUT + 2);
    chk("to_ack", ack, 4'b0001);
    chk("to_q", q_out, 0);
    chk("to_r", r_out, 0);
    chk("to_err", err_out, 1);
    req = '0; hang = 1'b0;
    @(negedge CLK);
    setop(0, 7, 2); req = 4'b0001;
    wait_ack(n);
    chk("post_to_lat", n, 7);
    chk("post_to_q", q_out, 3);
    chk("post_to_r", r_out, 1);
    chk("post_to_err", err_out, 0);
    req = '0;
    @(negedge CLK);

    // reset during WAIT
    setop(0, 11, 3); req = 4'b0001;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("mid_ack", ack, 0);
    chk("mid_busy", busy, 0);
    chk("mid_q", q_out, 0);
    chk("mid_r", r_out, 0);
    chk("mid_go", div_go, 0);
    chk("mid_divx", div_x, 0);
    @(negedge CLK);
    RST = 1'b0;
    wait_ack(n);
    chk("mid_lat", n, 7);
    chk("mid_ack2", ack, 4'b0001);
    chk("mid_q2", q_out, 3);
    chk("mid_r2", r_out, 2);
    req = '0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
